// File: rtl/yadan_test_monitor.sv
// Self-test status monitor for the yadan core: snoops regfile writeback and
// produces one pass/fail/timeout/hang verdict with a post-done settle window.
module yadan_test_monitor #(
    parameter int XLEN        = 32,
    parameter int DONE_IDX    = 26,
    parameter int PASS_IDX    = 27,
    parameter int TNUM_IDX    = 3,
    parameter int DONE_VAL    = 1,
    parameter int PASS_VAL    = 1,
    parameter int SETTLE_CYC  = 5,
    parameter int TIMEOUT_CYC = 50000,
    parameter int HANG_CYC    = 1024,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wb_we,
    input  logic [4:0]       wb_waddr,
    input  logic [XLEN-1:0]  wb_wdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             hang,
    output logic [XLEN-1:0]  fail_id,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_VERDICT = 3'd3;
    localparam logic [2:0] S_TOUT    = 3'd4;
    localparam logic [2:0] S_HANG    = 3'd5;

    localparam logic [4:0]       DONE_A = 5'(DONE_IDX);
    localparam logic [4:0]       PASS_A = 5'(PASS_IDX);
    localparam logic [4:0]       TNUM_A = 5'(TNUM_IDX);
    localparam logic [CNT_W-1:0] TOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [31:0]      HANG_V = 32'(HANG_CYC);
    localparam logic [31:0]      SETL_V = 32'(SETTLE_CYC);

    logic [2:0]       state;
    logic [XLEN-1:0]  pass_s;
    logic [XLEN-1:0]  tnum_s;
    logic [31:0]      settle_cnt;
    logic [31:0]      idle_cnt;

    logic             wr_ok;
    logic             done_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      idle_inc;
    logic [31:0]      settle_inc;

    // Writes to x0 never reach a shadow, whatever index parameters are chosen.
    assign wr_ok      = wb_we && (wb_waddr != 5'd0);
    assign done_hit   = wr_ok && (wb_waddr == DONE_A) && (wb_wdata == XLEN'(DONE_VAL));
    assign cnt_inc    = (cycle_cnt == {CNT_W{1'b1}}) ? cycle_cnt : cycle_cnt + 1'b1;
    assign idle_inc   = wb_we ? 32'd0 :
                        ((idle_cnt == 32'hFFFF_FFFF) ? idle_cnt : idle_cnt + 32'd1);
    assign settle_inc = settle_cnt + 32'd1;
    assign busy       = (state == S_RUN) || (state == S_SETTLE);

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            state      <= rst ? S_IDLE : S_RUN;
            pass_s     <= '0;
            tnum_s     <= '0;
            settle_cnt <= '0;
            idle_cnt   <= '0;
            cycle_cnt  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            hang       <= 1'b0;
            fail_id    <= '0;
        end else begin
            if (busy && wr_ok) begin
                if (wb_waddr == PASS_A) pass_s <= wb_wdata;
                if (wb_waddr == TNUM_A) tnum_s <= wb_wdata;
            end
            case (state)
                S_RUN: begin
                    cycle_cnt <= cnt_inc;
                    idle_cnt  <= idle_inc;
                    // A done write outranks a timeout or hang landing on the same edge.
                    if (done_hit) begin
                        state      <= (SETTLE_CYC == 0) ? S_VERDICT : S_SETTLE;
                        settle_cnt <= '0;
                    end else if (cnt_inc == TOUT_V) begin
                        state   <= S_TOUT;
                        timeout <= 1'b1;
                    end else if ((HANG_CYC != 0) && (idle_inc == HANG_V)) begin
                        state <= S_HANG;
                        hang  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    cycle_cnt  <= cnt_inc;
                    settle_cnt <= settle_inc;
                    if (settle_inc == SETL_V) state <= S_VERDICT;
                end
                S_VERDICT: begin
                    if (!done) begin
                        done    <= 1'b1;
                        pass    <= (pass_s == XLEN'(PASS_VAL));
                        fail    <= (pass_s != XLEN'(PASS_VAL));
                        fail_id <= tnum_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_yadan_test_monitor.sv
// Bench for yadan_test_monitor: two instances (settle 5 / hang 16, settle 0 / hang off)
// driven by directed and random writeback traffic, compared to an event-timeline model.
module tb_yadan_test_monitor;

    localparam int TOUT = 100;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        fail;
        logic        timeout;
        logic        hang;
        logic [31:0] fail_id;
        logic [31:0] cyc;
    } out_t;

    logic        clk = 1'b0;
    logic        rst, start, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    logic        a_busy, a_done, a_pass, a_fail, a_timeout, a_hang;
    logic [31:0] a_fail_id, a_cycle_cnt;
    logic        b_busy, b_done, b_pass, b_fail, b_timeout, b_hang;
    logic [31:0] b_fail_id, b_cycle_cnt;

    always #5 clk = ~clk;

    yadan_test_monitor #(.SETTLE_CYC(5), .TIMEOUT_CYC(TOUT), .HANG_CYC(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
        .timeout(a_timeout), .hang(a_hang), .fail_id(a_fail_id), .cycle_cnt(a_cycle_cnt));

    yadan_test_monitor #(.SETTLE_CYC(0), .TIMEOUT_CYC(TOUT), .HANG_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail),
        .timeout(b_timeout), .hang(b_hang), .fail_id(b_fail_id), .cycle_cnt(b_cycle_cnt));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: remembers when the run started, when done was written and when the
    // last writeback happened; outcome 0 none, 1 pass, 2 fail, 3 timeout, 4 hang.
    int          settle_p[2] = '{5, 0};
    int          hang_p[2]   = '{16, 0};
    int          edge_n      = 0;
    int          m_armed[2]  = '{0, 0};
    int          m_tstart[2] = '{0, 0};
    int          m_tdone[2]  = '{-1, -1};
    int          m_lastwe[2] = '{0, 0};
    int          m_out[2]    = '{0, 0};
    int          m_frozen[2] = '{0, 0};
    logic [31:0] m_pass_s[2] = '{0, 0};
    logic [31:0] m_tnum[2]   = '{0, 0};
    logic [31:0] m_fid[2]    = '{0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic out_t dut_out(input int k);
        out_t o;
        if (k == 0) o = '{a_busy, a_done, a_pass, a_fail, a_timeout, a_hang, a_fail_id, a_cycle_cnt};
        else        o = '{b_busy, b_done, b_pass, b_fail, b_timeout, b_hang, b_fail_id, b_cycle_cnt};
        return o;
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit we,
                              input logic [4:0] a, input logic [31:0] d);
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            if (r || s) begin
                m_armed[k]  = s && !r;
                m_tstart[k] = edge_n;
                m_tdone[k]  = -1;
                m_lastwe[k] = edge_n;
                m_out[k]    = 0;
                m_frozen[k] = 0;
                m_pass_s[k] = 0;
                m_tnum[k]   = 0;
                m_fid[k]    = 0;
            end else if (m_armed[k] != 0 && m_out[k] == 0) begin
                if (m_tdone[k] >= 0 && edge_n == m_tdone[k] + settle_p[k] + 1) begin
                    m_out[k]    = (m_pass_s[k] == 32'd1) ? 1 : 2;
                    m_fid[k]    = m_tnum[k];
                    m_frozen[k] = m_tdone[k] + settle_p[k] - m_tstart[k];
                end else begin
                    if (we && a != 5'd0) begin
                        if (a == 5'd27) m_pass_s[k] = d;
                        if (a == 5'd3)  m_tnum[k]   = d;
                    end
                    if (m_tdone[k] < 0) begin
                        if (we && a == 5'd26 && d == 32'd1) begin
                            m_tdone[k] = edge_n;
                        end else if (edge_n - m_tstart[k] == TOUT) begin
                            m_out[k]    = 3;
                            m_frozen[k] = TOUT;
                        end else if (we) begin
                            m_lastwe[k] = edge_n;
                        end else if (hang_p[k] != 0 && edge_n - m_lastwe[k] == hang_p[k]) begin
                            m_out[k]    = 4;
                            m_frozen[k] = edge_n - m_tstart[k];
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            out_t  o;
            string p;
            int    cyc;
            int    stop;
            bit    busy_e;
            o = dut_out(k);
            p = (k == 0) ? "a" : "b";
            busy_e = m_armed[k] != 0 && m_out[k] == 0 &&
                     (m_tdone[k] < 0 || edge_n < m_tdone[k] + settle_p[k]);
            if (m_armed[k] == 0)    cyc = 0;
            else if (m_out[k] != 0) cyc = m_frozen[k];
            else begin
                stop = edge_n;
                if (m_tdone[k] >= 0 && m_tdone[k] + settle_p[k] < stop) stop = m_tdone[k] + settle_p[k];
                cyc = stop - m_tstart[k];
            end
            check($sformatf("%s_busy@%0d", p, edge_n),    32'(o.busy),    32'(busy_e));
            check($sformatf("%s_done@%0d", p, edge_n),    32'(o.done),    32'(m_out[k] == 1 || m_out[k] == 2));
            check($sformatf("%s_pass@%0d", p, edge_n),    32'(o.pass),    32'(m_out[k] == 1));
            check($sformatf("%s_fail@%0d", p, edge_n),    32'(o.fail),    32'(m_out[k] == 2));
            check($sformatf("%s_timeout@%0d", p, edge_n), 32'(o.timeout), 32'(m_out[k] == 3));
            check($sformatf("%s_hang@%0d", p, edge_n),    32'(o.hang),    32'(m_out[k] == 4));
            check($sformatf("%s_fail_id@%0d", p, edge_n), o.fail_id,      m_fid[k]);
            check($sformatf("%s_cycle_cnt@%0d", p, edge_n), o.cyc,        32'(cyc));
        end
    endtask

    task automatic step(input bit r, input bit s, input bit we,
                        input logic [4:0] a, input logic [31:0] d);
        rst      = r;
        start    = s;
        wb_we    = we;
        wb_waddr = a;
        wb_wdata = d;
        @(posedge clk);
        model_edge(r, s, we, a, d);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic go();
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("reset_done", 32'(a_done | a_busy | a_hang | a_timeout), 32'd0);

        // T1: pass verdict six edges after the done write
        go(); wr(5'd3, 32'd7); wr(5'd27, 32'd1); wr(5'd26, 32'd1);
        idle(5);
        check("t1_not_yet", 32'(a_done), 32'd0);
        idle(1);
        check("t1_pass", 32'(a_pass), 32'd1);
        check("t1_fail", 32'(a_fail), 32'd0);
        check("t1_busy", 32'(a_busy), 32'd0);

        // T2: pass flag cleared inside the settle window
        go(); wr(5'd3, 32'h15); wr(5'd26, 32'd1); idle(1); wr(5'd27, 32'd0); idle(5);
        check("t2_fail", 32'(a_fail), 32'd1);
        check("t2_fail_id", a_fail_id, 32'h15);

        // T3: timeout with periodic x5 writes
        go();
        for (int i = 0; i < TOUT; i++) begin
            if (i % 4 == 0) wr(5'd5, 32'(i));
            else idle(1);
        end
        check("t3_timeout", 32'(a_timeout), 32'd1);
        check("t3_cycle_cnt", a_cycle_cnt, 32'd100);
        idle(10);
        check("t3_frozen", a_cycle_cnt, 32'd100);

        // T4: hang after 16 silent cycles; later writes ignored
        go(); wr(5'd5, 32'd1); idle(15);
        check("t4_no_hang", 32'(a_hang), 32'd0);
        idle(1);
        check("t4_hang", 32'(a_hang), 32'd1);
        wr(5'd26, 32'd1); idle(7);
        check("t4_sticky", 32'(a_hang), 32'd1);
        check("t4_no_pass", 32'(a_pass), 32'd0);

        // T5: ignored writes, then done on the timeout edge
        go(); wr(5'd0, 32'd1); wr(5'd26, 32'd2);
        check("t5_busy", 32'(a_busy), 32'd1);
        for (int i = 3; i < TOUT; i++) wr(5'd5, 32'(i));
        wr(5'd26, 32'd1);
        check("t5_no_timeout", 32'(a_timeout), 32'd0);
        idle(6);
        check("t5_done", 32'(a_done), 32'd1);

        // T6: reset inside settle, then a fresh passing run
        go(); wr(5'd26, 32'd1); idle(2);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("t6_rst_busy", 32'(a_busy | a_done), 32'd0);
        idle(3);
        go(); wr(5'd27, 32'd1); wr(5'd26, 32'd1); idle(6);
        check("t6_pass", 32'(a_pass), 32'd1);
        check("t6_cycle_cnt", a_cycle_cnt, 32'd7);

        // Random episodes, with occasional restart and reset mid-run
        for (int ep = 0; ep < 30; ep++) begin
            int len, dens;
            go();
            len  = $urandom_range(20, 140);
            dens = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                int          sel;
                logic [4:0]  a;
                logic [31:0] d;
                sel = $urandom % 16;
                case (sel % 8)
                    0: a = 5'd0;
                    1: a = 5'd3;
                    2: a = 5'd27;
                    3: a = (sel < 12) ? 5'd26 : 5'd5;
                    default: a = 5'($urandom);
                endcase
                d = (a == 5'd26 || a == 5'd27) ? 32'($urandom_range(0, 2)) : $urandom;
                if ($urandom % 150 == 0)      step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
                else if ($urandom % 150 == 0) go();
                else if ($urandom % dens == 0) wr(a, d);
                else idle(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
